regfile_2w2r_sb: RTL and testbench

- Parametrised successor to the single-write MIPS register bank: two write ports, two combinational read ports, optional write-to-read bypass, and a per-register pending-write scoreboard.
- Sits in the decode stage of the pipelined MIPS core.
- Write port 0 serves the ALU writeback; write port 1 serves the load/multi-cycle writeback.
- The scoreboard lets the hazard unit stall on registers with an outstanding write.

---
 rtl/regfile_2w2r_sb.sv | 120 ++++++++++++
 tb/tb_regfile_2w2r_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb
//   Decode-stage register bank for the pipelined MIPS core. It has two write
//   ports, two combinational read ports, an optional write-to-read bypass and
//   one pending-write bit per register.
//   Write port 0 serves the ALU writeback. Write port 1 serves the
//   load/multi-cycle writeback and wins when both ports target one address.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   we0/wa0/wd0         write port 0 (enable, address, data)
//   we1/wa1/wd1         write port 1 (enable, address, data)
//   rsv_en/rsv_addr     mark a register as having an outstanding write
//   ra1/ra2             read addresses
//   rd1/rd2             read data (combinational)
//   busy1/busy2         read address has an outstanding write (combinational)
//   conflict            registered: both write ports hit one address last edge
module regfile_2w2r_sb #(
  parameter int N        = 32,
  parameter int BR       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we0,
  input  logic [BR-1:0] wa0,
  input  logic [N-1:0]  wd0,
  input  logic          we1,
  input  logic [BR-1:0] wa1,
  input  logic [N-1:0]  wd1,
  input  logic          rsv_en,
  input  logic [BR-1:0] rsv_addr,
  input  logic [BR-1:0] ra1,
  input  logic [BR-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          busy1,
  output logic          busy2,
  output logic          conflict
);

  localparam int DEPTH = 1 << BR;

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;

  logic we0_eff;
  logic we1_eff;
  logic rsv_eff;
  logic conflict_nxt;

  // With a hard-wired zero register, any access to address 0 is squashed here.
  // Every later stage then needs no special case for writes or reserves.
  always_comb begin
    we0_eff = we0;
    we1_eff = we1;
    rsv_eff = rsv_en;
    if (ZERO_REG != 0) begin
      if (wa0 == '0)      we0_eff = 1'b0;
      if (wa1 == '0)      we1_eff = 1'b0;
      if (rsv_addr == '0) rsv_eff = 1'b0;
    end
    conflict_nxt = we0_eff && we1_eff && (wa0 == wa1);
  end

  // A write clears the pending bit. A reserve is applied last, so a new
  // claim on the register survives a write that lands on the same edge.
  always_comb begin
    pend_nxt = pend;
    if (we0_eff) pend_nxt[wa0] = 1'b0;
    if (we1_eff) pend_nxt[wa1] = 1'b0;
    if (rsv_eff) pend_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend     <= '0;
      conflict <= 1'b0;
    end else begin
      if (we0_eff) regs[wa0] <= wd0;
      // Port 1 is assigned second, so it wins a same-address collision.
      if (we1_eff) regs[wa1] <= wd1;
      pend     <= pend_nxt;
      conflict <= conflict_nxt;
    end
  end

  // Read port model. Port 1 is checked after port 0, which gives it forwarding
  // priority. Forwarded data also hides the pending bit, because the consumer
  // already receives the value it was waiting for.
  function automatic logic [N:0] read_port(input logic [BR-1:0] ra);
    logic [N-1:0] d;
    logic         b;
    d = regs[ra];
    b = pend[ra];
    if (BYPASS != 0) begin
      if (we0_eff && (wa0 == ra)) begin
        d = wd0;
        b = 1'b0;
      end
      if (we1_eff && (wa1 == ra)) begin
        d = wd1;
        b = 1'b0;
      end
    end
    if ((ZERO_REG != 0) && (ra == '0)) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  always_comb begin
    {busy1, rd1} = read_port(ra1);
    {busy2, rd2} = read_port(ra2);
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Bench for regfile_2w2r_sb.
// Two instances share one set of stimulus: "dut" has the bypass enabled and
// "dut_nb" has it disabled. Directed vectors are applied one per cycle, and
// hand-written sequences cover the full-depth sweep and asynchronous reset.
module tb_regfile_2w2r_sb;

  logic        clk;
  logic        rst_n;
  logic        we0, we1, rsv_en;
  logic [4:0]  wa0, wa1, rsv_addr, ra1, ra2;
  logic [31:0] wd0, wd1;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, conflict;
  logic        nb_busy1, nb_busy2, nb_conflict;

  int n_cmp;
  int n_err;

  regfile_2w2r_sb #(.N(32), .BR(5), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .conflict(conflict)
  );

  regfile_2w2r_sb #(.N(32), .BR(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra1(ra1), .ra2(ra2),
    .rd1(nb_rd1), .rd2(nb_rd2),
    .busy1(nb_busy1), .busy2(nb_busy2),
    .conflict(nb_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  raddr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic        e_cf;
    logic [31:0] e_nrd1;
    logic        e_nb1;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    ra1 = '0;
    ra2 = '0;

    //            we0  wa0    wd0           we1  wa1    wd1           rsv  raddr  ra1    ra2    rd1           rd2           b1   b2   cf   nb_rd1        nb_b1
    vt[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 5'd3, 32'h1234,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd3,  32'h1234,     32'h1234,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd0,  32'h1234,     32'h0,        1'b0, 1'b0, 1'b0, 32'h1234,     1'b0};
    vt[3]  = '{1'b1, 5'd7, 32'hAAAA,     1'b1, 5'd7, 32'h5555,     1'b0, 5'd0, 5'd7,  5'd3,  32'h5555,     32'h1234,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'h5555,     32'h0,        1'b0, 1'b0, 1'b1, 32'h5555,     1'b0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'h5555,     32'h0,        1'b0, 1'b0, 1'b0, 32'h5555,     1'b0};
    vt[6]  = '{1'b1, 5'd0, 32'h1,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd3,  5'd9,  32'h1234,     32'h0,        1'b0, 1'b0, 1'b0, 32'h1234,     1'b0};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd9,  32'h1234,     32'h0,        1'b0, 1'b1, 1'b0, 32'h1234,     1'b0};
    vt[10] = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9,  5'd9,  32'h99,       32'h99,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'h99,       32'h99,       1'b1, 1'b1, 1'b0, 32'h99,       1'b1};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h77,       1'b0, 5'd0, 5'd9,  5'd9,  32'h77,       32'h77,       1'b0, 1'b0, 1'b0, 32'h99,       1'b1};
    vt[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'h77,       32'h77,       1'b0, 1'b0, 1'b0, 32'h77,       1'b0};
    vt[14] = '{1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd7,  32'h55,       32'h5555,     1'b0, 1'b0, 1'b0, 32'h77,       1'b0};
    vt[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd7,  32'h55,       32'h5555,     1'b0, 1'b0, 1'b0, 32'h55,       1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: drive at the falling edge, check 1 ns later.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we0 = vt[i].we0; wa0 = vt[i].wa0; wd0 = vt[i].wd0;
      we1 = vt[i].we1; wa1 = vt[i].wa1; wd1 = vt[i].wd1;
      rsv_en = vt[i].rsv; rsv_addr = vt[i].raddr;
      ra1 = vt[i].ra1; ra2 = vt[i].ra2;
      #1;
      chk($sformatf("v%0d rd1", i), rd1, vt[i].e_rd1);
      chk($sformatf("v%0d rd2", i), rd2, vt[i].e_rd2);
      chk($sformatf("v%0d busy1", i), {31'b0, busy1}, {31'b0, vt[i].e_b1});
      chk($sformatf("v%0d busy2", i), {31'b0, busy2}, {31'b0, vt[i].e_b2});
      chk($sformatf("v%0d conflict", i), {31'b0, conflict}, {31'b0, vt[i].e_cf});
      chk($sformatf("v%0d nb_rd1", i), nb_rd1, vt[i].e_nrd1);
      chk($sformatf("v%0d nb_busy1", i), {31'b0, nb_busy1}, {31'b0, vt[i].e_nb1});
    end

    // Full-depth sweep: reg[i] = i*3. Odd addresses use port 0, even use port 1.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      if (i % 2 == 1) begin
        we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i * 3);
      end else begin
        we1 = 1'b1; wa1 = 5'(i); wd1 = 32'(i * 3);
      end
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep rd1[%0d]", i), rd1, 32'(i * 3));
      chk($sformatf("sweep rd2[%0d]", 31 - i), rd2, 32'((31 - i) * 3));
      chk($sformatf("sweep nb_rd1[%0d]", i), nb_rd1, 32'(i * 3));
      chk($sformatf("sweep busy[%0d]", i), {30'b0, busy1, busy2}, 32'h0);
    end

    // Asynchronous reset mid-run: set up a collision and a reserve on reg 5,
    // then drop rst_n between clock edges.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    @(negedge clk);
    idle();
    ra1 = 5'd5;
    ra2 = 5'd3;
    #1;
    chk("pre-reset rd1", rd1, 32'hDEADBEEF);
    chk("pre-reset busy1", {31'b0, busy1}, 32'h1);
    chk("pre-reset conflict", {31'b0, conflict}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset rd1", rd1, 32'h0);
    chk("reset rd2", rd2, 32'h0);
    chk("reset busy1", {31'b0, busy1}, 32'h0);
    chk("reset conflict", {31'b0, conflict}, 32'h0);
    chk("reset nb_rd1", nb_rd1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset rd1", rd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
